// File: rtl/rename_pkg.sv
// Shared types and helpers for the 3-wide rename stage and its physical-register free list.
package rename_pkg;

    localparam int NUM_LANES = 3;

    typedef enum logic {RUN, RECOVER} alloc_state_e;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    // Thermometer mask with the lowest n bits set.
    function automatic logic [2:0] low_mask3(input logic [1:0] n);
        case (n)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/circular_buffer_3port.sv
// Physical-register free list: a FIFO of tag indices with three pop and three push ports, reset full.
module circular_buffer_3port
    import rename_pkg::*;
#(
    parameter int BUFFER_DEPTH = 32,
    parameter int ADDR_WIDTH   = $clog2(BUFFER_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [2:0]                 read_en,
    output logic [2:0][ADDR_WIDTH:0]   read_data,
    output logic [2:0]                 read_valid,
    input  logic [2:0]                 write_en,
    input  logic [2:0][ADDR_WIDTH-1:0] write_data,
    output logic [ADDR_WIDTH:0]        buffer_count,
    output logic                       buffer_full
);
    localparam int CW = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0]       mem [BUFFER_DEPTH];
    logic [ADDR_WIDTH-1:0]       rd_ptr;
    logic [ADDR_WIDTH-1:0]       wr_ptr;
    logic [2:0][ADDR_WIDTH-1:0]  wr_addr;
    logic [1:0]                  n_rd;
    logic [1:0]                  n_wr;
    logic [1:0]                  wr_rank;

    assign buffer_full = (buffer_count == CW'(BUFFER_DEPTH));

    // Pops come from the head in port order; pushes are packed so sparse write enables stay contiguous.
    always_comb begin
        n_rd       = popcount3(read_en);
        n_wr       = popcount3(write_en);
        wr_rank    = '0;
        wr_addr    = '0;
        read_data  = '0;
        read_valid = '0;
        for (int i = 0; i < 3; i++) begin
            read_valid[i] = (buffer_count > CW'(i));
            read_data[i]  = read_valid[i] ? {1'b1, mem[rd_ptr + ADDR_WIDTH'(i)]} : '0;
            wr_addr[i]    = wr_ptr + ADDR_WIDTH'(wr_rank);
            if (write_en[i]) begin
                wr_rank = wr_rank + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            buffer_count <= CW'(BUFFER_DEPTH);
            for (int i = 0; i < BUFFER_DEPTH; i++) begin
                mem[i] <= ADDR_WIDTH'(i);
            end
        end else begin
            rd_ptr       <= rd_ptr + ADDR_WIDTH'(n_rd);
            wr_ptr       <= wr_ptr + ADDR_WIDTH'(n_wr);
            buffer_count <= buffer_count - CW'(n_rd) + CW'(n_wr);
            for (int i = 0; i < 3; i++) begin
                if (write_en[i]) begin
                    mem[wr_addr[i]] <= write_data[i];
                end
            end
        end
    end

endmodule

// File: rtl/phys_reg_alloc_ctrl.sv
// Rename-stage controller for the physical-register free list: all-or-nothing tag grants,
// retire returns, in-flight tracking and flush replay of squashed tags.
module phys_reg_alloc_ctrl
    import rename_pkg::*;
#(
    parameter int BUFFER_DEPTH = 32,
    parameter int ADDR_WIDTH   = $clog2(BUFFER_DEPTH)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_LANES-1:0]               lane_req_i,
    input  logic                               rename_hold_i,
    output logic [NUM_LANES-1:0]               lane_grant_o,
    output logic [NUM_LANES-1:0][ADDR_WIDTH:0] lane_tag_o,
    output logic                               alloc_stall_o,
    input  logic [NUM_LANES-1:0]               retire_dest_i,
    input  logic                               flush_i,
    output logic                               recover_busy_o,
    output logic [NUM_LANES-1:0]               fl_read_en_o,
    input  logic [NUM_LANES-1:0][ADDR_WIDTH:0] fl_read_data_i,
    input  logic [NUM_LANES-1:0]               fl_read_valid_i,
    output logic [NUM_LANES-1:0]               fl_write_en_o,
    input  logic [ADDR_WIDTH:0]                fl_count_i,
    input  logic                               fl_full_i
);
    localparam int CW = ADDR_WIDTH + 1;

    alloc_state_e    state_q, state_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   recover_q, recover_d;
    logic [1:0]      n_req;
    logic [1:0]      n_ret;
    logic [1:0]      n_grant;
    logic [1:0]      rank;
    logic [1:0]      k;
    logic            req_ok;

    assign recover_busy_o = (state_q == RECOVER);

    // Read ports are used compacted from port 0, so the k-th requesting lane takes read_data[k].
    always_comb begin
        state_d       = state_q;
        inflight_d    = inflight_q;
        recover_d     = recover_q;
        lane_grant_o  = '0;
        lane_tag_o    = '0;
        alloc_stall_o = 1'b0;
        fl_read_en_o  = '0;
        fl_write_en_o = '0;
        n_req         = popcount3(lane_req_i);
        n_ret         = popcount3(retire_dest_i);
        n_grant       = '0;
        rank          = '0;
        k             = '0;
        req_ok        = !flush_i && !rename_hold_i && (fl_count_i >= CW'(n_req));

        case (state_q)
            RUN: begin
                if (n_req != 2'd0) begin
                    if (req_ok) begin
                        n_grant      = n_req;
                        lane_grant_o = lane_req_i;
                        fl_read_en_o = low_mask3(n_req);
                        for (int i = 0; i < NUM_LANES; i++) begin
                            if (lane_req_i[i]) begin
                                lane_tag_o[i] = fl_read_data_i[rank];
                                rank          = rank + 2'd1;
                            end
                        end
                    end else begin
                        alloc_stall_o = 1'b1;
                    end
                end
                fl_write_en_o = fl_full_i ? '0 : retire_dest_i;
                if (flush_i) begin
                    recover_d  = inflight_q - CW'(n_ret);
                    inflight_d = '0;
                    if (recover_d != '0) begin
                        state_d = RECOVER;
                    end
                end else begin
                    inflight_d = inflight_q + CW'(n_grant) - CW'(n_ret);
                end
            end
            RECOVER: begin
                alloc_stall_o = (n_req != 2'd0);
                k             = (recover_q >= CW'(3)) ? 2'd3 : recover_q[1:0];
                fl_write_en_o = low_mask3(k);
                recover_d     = recover_q - CW'(k);
                if (recover_d == '0) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        if (!rst_n) begin
            lane_grant_o  = '0;
            lane_tag_o    = '0;
            fl_read_en_o  = '0;
            fl_write_en_o = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            inflight_q <= '0;
            recover_q  <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            recover_q  <= recover_d;
        end
    end

    a_read_valid: assert property (@(posedge clk) disable iff (!rst_n)
        (fl_read_en_o & ~fl_read_valid_i) == '0);
    a_no_write_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(state_q == RUN && retire_dest_i != '0 && fl_full_i));
    a_recover_no_retire: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == RECOVER) |-> (retire_dest_i == '0));
    a_inflight_floor: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == RUN) |-> (int'(inflight_q) + int'(n_grant) >= int'(n_ret)));
    a_inflight_ceiling: assert property (@(posedge clk) disable iff (!rst_n)
        int'(inflight_d) <= BUFFER_DEPTH);

endmodule
